// File: rtl/dest_reg_pipe_if.sv
// Bus between the ID-stage decode logic and the destination-register
// tracking pipeline. The master drives the ID-stage fields and the
// global Hold/Flush controls. The slave (dest_reg_pipe) returns the
// tracked destination registers, the forwarding selects and the
// load-use stall request.
interface dest_reg_pipe_if #(
    parameter int REG_W = 5
);
    // ID-stage side
    logic             Hold;
    logic             Flush;
    logic [REG_W-1:0] WrReg_ID;
    logic             RegWrite_ID;
    logic             MemRead_ID;
    logic [REG_W-1:0] Rs_ID;
    logic [REG_W-1:0] Rt_ID;
    logic             UsesRt_ID;

    // Pipeline-tracking results
    logic [REG_W-1:0] WrReg_EX;
    logic [REG_W-1:0] WrReg_MEM;
    logic [REG_W-1:0] WrReg_WB;
    logic             RegWrite_WB;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic             LoadUse;

    modport master (
        output Hold, Flush, WrReg_ID, RegWrite_ID, MemRead_ID,
               Rs_ID, Rt_ID, UsesRt_ID,
        input  WrReg_EX, WrReg_MEM, WrReg_WB, RegWrite_WB,
               ForwardA, ForwardB, LoadUse
    );

    modport slave (
        input  Hold, Flush, WrReg_ID, RegWrite_ID, MemRead_ID,
               Rs_ID, Rt_ID, UsesRt_ID,
        output WrReg_EX, WrReg_MEM, WrReg_WB, RegWrite_WB,
               ForwardA, ForwardB, LoadUse
    );
endinterface

// File: rtl/dest_reg_pipe.sv
// Destination-register tracking pipeline.
// Carries the destination register number, RegWrite and MemRead from ID
// through EX, MEM and WB. The tracked state drives the EX operand
// forwarding selects and the load-use stall request.
// Register 0 is hard-wired zero. A write to it is dropped at capture, so
// $0 never forwards and never stalls.
module dest_reg_pipe #(
    parameter int REG_W  = 5,
    parameter bit HAZ_EN = 1'b1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    dest_reg_pipe_if.slave bus
);

    // Forwarding select encoding
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // EX stage register
    logic [REG_W-1:0] r_ex_wrreg;
    logic             r_ex_regwrite;
    logic             r_ex_memread;
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;

    // MEM stage register
    logic [REG_W-1:0] r_mem_wrreg;
    logic             r_mem_regwrite;
    logic             r_mem_memread;

    // WB stage register
    logic [REG_W-1:0] r_wb_wrreg;
    logic             r_wb_regwrite;

    // Combinational helpers
    logic             w_id_regwrite;
    logic             w_load_use;
    logic             w_bubble;
    logic             w_mem_src_ok;
    logic             w_mem_a_hit;
    logic             w_mem_b_hit;
    logic             w_wb_a_hit;
    logic             w_wb_b_hit;
    logic             w_ld_rs_hit;
    logic             w_ld_rt_hit;

    // MEM is the younger producer, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic mem_hit,
                                           input logic wb_hit);
        if (mem_hit)
            return FWD_MEM;
        else if (wb_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    // Capture-side qualification: a write to $0 is discarded here so the
    // downstream match logic never has to special-case register 0.
    always_comb begin
        w_id_regwrite = bus.RegWrite_ID && (bus.WrReg_ID != '0);
    end

    // Load-use detection against the instruction currently in ID.
    // A load's data is only available from WB, so one bubble is needed.
    always_comb begin
        w_ld_rs_hit = (r_ex_wrreg == bus.Rs_ID);
        w_ld_rt_hit = bus.UsesRt_ID && (r_ex_wrreg == bus.Rt_ID);
        w_load_use  = HAZ_EN && r_ex_memread && r_ex_regwrite &&
                      (w_ld_rs_hit || w_ld_rt_hit);
        w_bubble    = bus.Flush || w_load_use;
    end

    // Forwarding source qualification from stage registers only; the ID
    // inputs have no path into ForwardA/B. A load sitting in MEM has no
    // data yet, so it is not a valid MEM source.
    always_comb begin
        w_mem_src_ok = r_mem_regwrite && !r_mem_memread;
        w_mem_a_hit  = w_mem_src_ok && (r_mem_wrreg == r_ex_rs);
        w_mem_b_hit  = w_mem_src_ok && (r_mem_wrreg == r_ex_rt);
        w_wb_a_hit   = r_wb_regwrite && (r_wb_wrreg == r_ex_rs);
        w_wb_b_hit   = r_wb_regwrite && (r_wb_wrreg == r_ex_rt);
    end

    // ---- ID -> EX boundary: capture ID fields, or a bubble on flush/stall
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_ex_wrreg    <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
        end else if (!bus.Hold) begin
            if (w_bubble) begin
                r_ex_wrreg    <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
                r_ex_rs       <= '0;
                r_ex_rt       <= '0;
            end else begin
                r_ex_wrreg    <= bus.WrReg_ID;
                r_ex_regwrite <= w_id_regwrite;
                r_ex_memread  <= bus.MemRead_ID;
                r_ex_rs       <= bus.Rs_ID;
                r_ex_rt       <= bus.Rt_ID;
            end
        end
    end

    // ---- EX -> MEM boundary: advance unless the whole pipe is frozen
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_mem_wrreg    <= '0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
        end else if (!bus.Hold) begin
            r_mem_wrreg    <= r_ex_wrreg;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memread  <= r_ex_memread;
        end
    end

    // ---- MEM -> WB boundary: advance unless the whole pipe is frozen
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_wb_wrreg    <= '0;
            r_wb_regwrite <= 1'b0;
        end else if (!bus.Hold) begin
            r_wb_wrreg    <= r_mem_wrreg;
            r_wb_regwrite <= r_mem_regwrite;
        end
    end

    // Drive the results onto the bus.
    always_comb begin
        bus.WrReg_EX    = r_ex_wrreg;
        bus.WrReg_MEM   = r_mem_wrreg;
        bus.WrReg_WB    = r_wb_wrreg;
        bus.RegWrite_WB = r_wb_regwrite;
        bus.ForwardA    = fwd_sel(w_mem_a_hit, w_wb_a_hit);
        bus.ForwardB    = fwd_sel(w_mem_b_hit, w_wb_b_hit);
        bus.LoadUse     = w_load_use;
    end

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Self-checking bench for dest_reg_pipe: directed scenarios plus a
// scoreboarded back-to-back stream checked at the WB stage.
module tb_dest_reg_pipe;

    logic Clk;
    logic Rst_n;

    int errors;
    int checks;

    typedef struct {
        logic [4:0] wr;
        logic       rw;
    } wb_exp_t;

    wb_exp_t sb_q[$];

    dest_reg_pipe_if #(.REG_W(5)) bus ();

    dest_reg_pipe #(.REG_W(5), .HAZ_EN(1'b1)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge, then let outputs settle.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] wr, input logic rw, input logic mr,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic ut);
        bus.WrReg_ID    = wr;
        bus.RegWrite_ID = rw;
        bus.MemRead_ID  = mr;
        bus.Rs_ID       = rs;
        bus.Rt_ID       = rt;
        bus.UsesRt_ID   = ut;
        #1;
    endtask

    task automatic idle();
        set_id(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        bus.Hold  = 1'b0;
        bus.Flush = 1'b0;
        set_id(5'd7, 1'b1, 1'b0, 5'd7, 5'd7, 1'b1);
        tick(); tick(); tick();
        checks++;
        if (bus.WrReg_WB !== 5'd7 || bus.RegWrite_WB !== 1'b1) begin
            errors++;
            $display("FAIL reset_fill: WB wr=%0d rw=%0b, want 7/1", bus.WrReg_WB, bus.RegWrite_WB);
        end
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        idle();
        checks++;
        if (bus.WrReg_EX !== 5'd0 || bus.WrReg_MEM !== 5'd0 || bus.WrReg_WB !== 5'd0) begin
            errors++;
            $display("FAIL reset_wrreg: EX=%0d MEM=%0d WB=%0d, want 0/0/0",
                     bus.WrReg_EX, bus.WrReg_MEM, bus.WrReg_WB);
        end
        checks++;
        if (bus.RegWrite_WB !== 1'b0 || bus.ForwardA !== 2'b00 ||
            bus.ForwardB !== 2'b00 || bus.LoadUse !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rw=%0b fa=%b fb=%b lu=%0b, want 0/00/00/0",
                     bus.RegWrite_WB, bus.ForwardA, bus.ForwardB, bus.LoadUse);
        end
    endtask

    task automatic test_mem_fwd();
        set_id(5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1);
        tick();
        set_id(5'd0, 1'b0, 1'b0, 5'd3, 5'd9, 1'b1);
        tick();
        idle();
        checks++;
        if (bus.ForwardA !== 2'b10 || bus.ForwardB !== 2'b00) begin
            errors++;
            $display("FAIL mem_fwd: fa=%b fb=%b, want 10/00", bus.ForwardA, bus.ForwardB);
        end
    endtask

    task automatic test_priority();
        set_id(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); tick();
        set_id(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); tick();
        set_id(5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 1'b1); tick();
        idle();
        checks++;
        if (bus.ForwardA !== 2'b10 || bus.ForwardB !== 2'b10) begin
            errors++;
            $display("FAIL prio_mem: fa=%b fb=%b, want 10/10", bus.ForwardA, bus.ForwardB);
        end
        set_id(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); tick();
        set_id(5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); tick();
        set_id(5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 1'b1); tick();
        idle();
        checks++;
        if (bus.ForwardA !== 2'b01 || bus.ForwardB !== 2'b01) begin
            errors++;
            $display("FAIL prio_wb: fa=%b fb=%b, want 01/01", bus.ForwardA, bus.ForwardB);
        end
    endtask

    task automatic test_load_use();
        idle(); tick(); tick(); tick();
        set_id(5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        tick();
        set_id(5'd8, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0);
        checks++;
        if (bus.LoadUse !== 1'b1) begin
            errors++;
            $display("FAIL ldu_assert: lu=%0b, want 1", bus.LoadUse);
        end
        tick();
        checks++;
        if (bus.WrReg_EX !== 5'd0 || bus.WrReg_MEM !== 5'd4 || bus.LoadUse !== 1'b0) begin
            errors++;
            $display("FAIL ldu_bubble: EX=%0d MEM=%0d lu=%0b, want 0/4/0",
                     bus.WrReg_EX, bus.WrReg_MEM, bus.LoadUse);
        end
        tick();
        idle();
        checks++;
        if (bus.ForwardA !== 2'b01 || bus.WrReg_EX !== 5'd8) begin
            errors++;
            $display("FAIL ldu_fwd: fa=%b EX=%0d, want 01/8", bus.ForwardA, bus.WrReg_EX);
        end
        // Rt match only counts when the instruction actually reads rt.
        set_id(5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        tick();
        set_id(5'd9, 1'b1, 1'b0, 5'd1, 5'd4, 1'b1);
        checks++;
        if (bus.LoadUse !== 1'b1) begin
            errors++;
            $display("FAIL ldu_rt_used: lu=%0b, want 1", bus.LoadUse);
        end
        set_id(5'd9, 1'b1, 1'b0, 5'd1, 5'd4, 1'b0);
        checks++;
        if (bus.LoadUse !== 1'b0) begin
            errors++;
            $display("FAIL ldu_rt_unused: lu=%0b, want 0", bus.LoadUse);
        end
        // Unflagged rt reader reaches EX with the load in MEM: no MEM forward.
        tick();
        idle();
        checks++;
        if (bus.ForwardB !== 2'b00 || bus.ForwardA !== 2'b00 || bus.WrReg_EX !== 5'd9) begin
            errors++;
            $display("FAIL ld_in_mem: fa=%b fb=%b EX=%0d, want 00/00/9",
                     bus.ForwardA, bus.ForwardB, bus.WrReg_EX);
        end
    endtask

    task automatic test_zero_reg();
        idle(); tick(); tick(); tick();
        set_id(5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1);
        tick();
        set_id(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
        checks++;
        if (bus.LoadUse !== 1'b0) begin
            errors++;
            $display("FAIL zero_ldu: lu=%0b, want 0", bus.LoadUse);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.ForwardA !== 2'b00 || bus.ForwardB !== 2'b00 || bus.RegWrite_WB !== 1'b0) begin
                errors++;
                $display("FAIL zero_fwd%0d: fa=%b fb=%b rw=%0b, want 00/00/0",
                         k, bus.ForwardA, bus.ForwardB, bus.RegWrite_WB);
            end
        end
    endtask

    task automatic test_hold_flush();
        set_id(5'd10, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); tick();
        set_id(5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); tick();
        set_id(5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); tick();
        bus.Hold  = 1'b1;
        bus.Flush = 1'b1;
        set_id(5'd13, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1);
        tick();
        checks++;
        if (bus.WrReg_EX !== 5'd12 || bus.WrReg_MEM !== 5'd11 ||
            bus.WrReg_WB !== 5'd10 || bus.RegWrite_WB !== 1'b1) begin
            errors++;
            $display("FAIL hold: EX=%0d MEM=%0d WB=%0d rw=%0b, want 12/11/10/1",
                     bus.WrReg_EX, bus.WrReg_MEM, bus.WrReg_WB, bus.RegWrite_WB);
        end
        bus.Hold = 1'b0;
        tick();
        bus.Flush = 1'b0;
        #1;
        checks++;
        if (bus.WrReg_EX !== 5'd0 || bus.WrReg_MEM !== 5'd12 || bus.WrReg_WB !== 5'd11) begin
            errors++;
            $display("FAIL flush: EX=%0d MEM=%0d WB=%0d, want 0/12/11",
                     bus.WrReg_EX, bus.WrReg_MEM, bus.WrReg_WB);
        end
        // LoadUse stays visible under Hold but only bubbles once Hold drops.
        set_id(5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        tick();
        bus.Hold = 1'b1;
        set_id(5'd14, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0);
        tick();
        checks++;
        if (bus.LoadUse !== 1'b1 || bus.WrReg_EX !== 5'd4) begin
            errors++;
            $display("FAIL hold_ldu: lu=%0b EX=%0d, want 1/4", bus.LoadUse, bus.WrReg_EX);
        end
        bus.Hold = 1'b0;
        tick();
        checks++;
        if (bus.WrReg_EX !== 5'd0 || bus.WrReg_MEM !== 5'd4) begin
            errors++;
            $display("FAIL hold_ldu_release: EX=%0d MEM=%0d, want 0/4",
                     bus.WrReg_EX, bus.WrReg_MEM);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        wb_exp_t e;
        wb_exp_t got;
        logic [4:0] wr;
        logic       rw;
        sb_q.delete();
        for (int n = 0; n < 40; n++) begin
            wr = 5'($urandom_range(0, 31));
            rw = 1'($urandom_range(0, 1));
            set_id(wr, rw, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)));
            e.wr = wr;
            e.rw = rw && (wr != 5'd0);
            sb_q.push_back(e);
            tick();
            if (sb_q.size() == 3) begin
                got = sb_q.pop_front();
                checks++;
                if (bus.WrReg_WB !== got.wr || bus.RegWrite_WB !== got.rw) begin
                    errors++;
                    $display("FAIL b2b_%0d: WB wr=%0d rw=%0b, want %0d/%0b",
                             n, bus.WrReg_WB, bus.RegWrite_WB, got.wr, got.rw);
                end
            end
        end
        idle();
        for (int d = 0; d < 2; d++) begin
            tick();
            got = sb_q.pop_front();
            checks++;
            if (bus.WrReg_WB !== got.wr || bus.RegWrite_WB !== got.rw) begin
                errors++;
                $display("FAIL b2b_drain%0d: WB wr=%0d rw=%0b, want %0d/%0b",
                         d, bus.WrReg_WB, bus.RegWrite_WB, got.wr, got.rw);
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        Rst_n     = 1'b0;
        bus.Hold  = 1'b0;
        bus.Flush = 1'b0;
        idle();
        tick(); tick();
        Rst_n = 1'b1;
        test_reset();
        test_mem_fwd();
        test_priority();
        test_load_use();
        test_zero_reg();
        test_hold_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
